line_drive_sequencer: RTL and testbench

- Drive-policy controller for the line-following car.
- Takes the 3-way track sensors (active-low: 0 = line seen) and the 6-bit sonic distance, and sequences the Motor block's mode/speed inputs.
- Adds sensor debouncing, speed ramping, obstacle stop/resume with hysteresis, and lost-line detection.
- Sits between Sonic/track inputs and Motor, replacing ad-hoc top-level steering logic.

---
 rtl/line_drive_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_line_drive_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_drive_sequencer.sv
// rtl/line_drive_sequencer.sv - drive-policy sequencer between track/sonic sensors and the Motor block
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous reset, active-low
//   run          1 = drive enabled, 0 = stop
//   left_track   raw left line sensor, 0 = line seen
//   mid_track    raw middle line sensor, 0 = line seen
//   right_track  raw right line sensor, 0 = line seen
//   distance     sonic distance, unsigned
//   mode         Motor mode: 11 forward, 10 turn left, 01 turn right, 00 idle
//   speed        Motor PWM duty
//   state_o      current state: 0 IDLE, 1 FORWARD, 2 TURN_L, 3 TURN_R, 4 BLOCKED, 5 LOST
//   blocked      1 while in BLOCKED
//   lost         1 while in LOST

module line_drive_sequencer #(
    parameter int         DEB_CYCLES   = 100000,
    parameter int         RAMP_DIV     = 100000,
    parameter logic [9:0] RAMP_STEP    = 10'd40,
    parameter logic [9:0] CRUISE_SPEED = 10'd800,
    parameter logic [9:0] TURN_SPEED   = 10'd600,
    parameter logic [5:0] STOP_DIST    = 6'd8,
    parameter logic [5:0] RESUME_DIST  = 6'd12,
    parameter int         LOST_CYCLES  = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       left_track,
    input  logic       mid_track,
    input  logic       right_track,
    input  logic [5:0] distance,
    output logic [1:0] mode,
    output logic [9:0] speed,
    output logic [2:0] state_o,
    output logic       blocked,
    output logic       lost
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int PRE_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int LOST_W = $clog2(LOST_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(RAMP_DIV - 1);
    localparam logic [LOST_W-1:0] LOST_MAX = LOST_W'(LOST_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FORWARD = 3'd1,
        S_TURN_L  = 3'd2,
        S_TURN_R  = 3'd3,
        S_BLOCKED = 3'd4,
        S_LOST    = 3'd5
    } state_t;

    function automatic logic [1:0] mode_of(input state_t s);
        case (s)
            S_FORWARD: mode_of = 2'b11;
            S_TURN_L:  mode_of = 2'b10;
            S_TURN_R:  mode_of = 2'b01;
            default:   mode_of = 2'b00;
        endcase
    endfunction

    // ---------------- track synchronizer and debounce ----------------
    // Bit order everywhere: [2] = left, [1] = mid, [0] = right.
    logic [2:0] raw_tracks;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] deb;

    assign raw_tracks = {left_track, mid_track, right_track};

    // Synchronizer resets to "no line" so the debouncer sees no false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
        end else begin
            sync1 <= raw_tracks;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_deb
        logic [DEB_W-1:0] cnt;
        logic             bit_q;

        // Counter measures how long the synced bit has disagreed with the
        // debounced bit; the flip happens on the DEB_CYCLES-th disagreeing cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                bit_q <= 1'b1;
            end else if (sync2[i] != bit_q) begin
                if (cnt == DEB_LAST) begin
                    bit_q <= sync2[i];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + DEB_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end

        assign deb[i] = bit_q;
    end

    logic l_bit;
    logic m_bit;
    logic r_bit;

    assign l_bit = deb[2];
    assign m_bit = deb[1];
    assign r_bit = deb[0];

    // ---------------- state and lost timer ----------------
    state_t state;
    state_t state_nxt;
    state_t saved;
    state_t saved_nxt;

    logic              driving;
    logic [LOST_W-1:0] lost_cnt;
    logic              lost_hit;

    assign driving  = (state == S_FORWARD) || (state == S_TURN_L) || (state == S_TURN_R);
    assign lost_hit = (lost_cnt == LOST_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_cnt <= '0;
        end else if (driving && (deb == 3'b111)) begin
            if (!lost_hit) begin
                lost_cnt <= lost_cnt + LOST_W'(1);
            end
        end else begin
            lost_cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        saved_nxt = saved;
        if (!run) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: state_nxt = S_FORWARD;
                S_FORWARD, S_TURN_L, S_TURN_R: begin
                    if (distance <= STOP_DIST) begin
                        state_nxt = S_BLOCKED;
                        saved_nxt = state;
                    end else if (lost_hit) begin
                        state_nxt = S_LOST;
                    end else if (state == S_FORWARD) begin
                        // Both side sensors on the line is an intersection: keep going.
                        if (!r_bit && l_bit) begin
                            state_nxt = S_TURN_R;
                        end else if (!l_bit && r_bit) begin
                            state_nxt = S_TURN_L;
                        end
                    end else if (!m_bit) begin
                        state_nxt = S_FORWARD;
                    end
                end
                S_BLOCKED: begin
                    // Between the two thresholds the car stays put (hysteresis).
                    if (distance >= RESUME_DIST) begin
                        state_nxt = saved;
                    end
                end
                S_LOST: begin
                    if (deb != 3'b111) begin
                        state_nxt = S_FORWARD;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            saved   <= S_FORWARD;
            mode    <= 2'b00;
            blocked <= 1'b0;
            lost    <= 1'b0;
        end else begin
            state   <= state_nxt;
            saved   <= saved_nxt;
            mode    <= mode_of(state_nxt);
            blocked <= (state_nxt == S_BLOCKED);
            lost    <= (state_nxt == S_LOST);
        end
    end

    assign state_o = state;

    // ---------------- speed ramp ----------------
    logic [PRE_W-1:0] pre_cnt;
    logic             pre_wrap;
    logic [9:0]       target;
    logic [10:0]      speed_sum;

    assign pre_wrap  = (pre_cnt == PRE_LAST);
    assign speed_sum = {1'b0, speed} + {1'b0, RAMP_STEP};

    always_comb begin
        target = 10'd0;
        case (state)
            S_FORWARD:          target = CRUISE_SPEED;
            S_TURN_L, S_TURN_R: target = TURN_SPEED;
            default:            target = 10'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (pre_wrap) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // Deceleration is immediate; acceleration steps only on prescaler wrap
    // and is clamped so the target is never overshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed <= 10'd0;
        end else if (target < speed) begin
            speed <= target;
        end else if ((target > speed) && pre_wrap) begin
            if (speed_sum > {1'b0, target}) begin
                speed <= target;
            end else begin
                speed <= speed_sum[9:0];
            end
        end
    end

endmodule

// File: tb/tb_line_drive_sequencer.sv
// tb/tb_line_drive_sequencer.sv - randomized bench for line_drive_sequencer against a behavioural model

module tb_line_drive_sequencer;

    localparam int DEB    = 4;
    localparam int DIV    = 2;
    localparam int STEP   = 100;
    localparam int CRUISE = 800;
    localparam int TURN   = 600;
    localparam int STOP   = 8;
    localparam int RESUME = 12;
    localparam int LOSTN  = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       left_track = 1'b1;
    logic       mid_track = 1'b1;
    logic       right_track = 1'b1;
    logic [5:0] distance = 6'd40;
    logic [1:0] mode;
    logic [9:0] speed;
    logic [2:0] state_o;
    logic       blocked;
    logic       lost;

    line_drive_sequencer #(
        .DEB_CYCLES  (DEB),
        .RAMP_DIV    (DIV),
        .RAMP_STEP   (10'(STEP)),
        .CRUISE_SPEED(10'(CRUISE)),
        .TURN_SPEED  (10'(TURN)),
        .STOP_DIST   (6'(STOP)),
        .RESUME_DIST (6'(RESUME)),
        .LOST_CYCLES (LOSTN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .left_track (left_track),
        .mid_track  (mid_track),
        .right_track(right_track),
        .distance   (distance),
        .mode       (mode),
        .speed      (speed),
        .state_o    (state_o),
        .blocked    (blocked),
        .lost       (lost)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // States: 0 IDLE, 1 FORWARD, 2 TURN_L, 3 TURN_R, 4 BLOCKED, 5 LOST
    int         m_state;
    int         m_saved;
    int         m_lost_cnt;
    int         m_speed;
    int         m_edge;
    logic [2:0] m_deb;
    logic [2:0] raw_q[$];
    logic [2:0] sync_q[$];

    function automatic int target_of(input int s);
        if (s == 1) return CRUISE;
        if (s == 2 || s == 3) return TURN;
        return 0;
    endfunction

    function automatic int mode_of(input int s);
        if (s == 1) return 3;
        if (s == 2) return 2;
        if (s == 3) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_saved = 1;
        m_lost_cnt = 0;
        m_speed = 0;
        m_edge = 0;
        m_deb = 3'b111;
        raw_q.delete();
        sync_q.delete();
    endtask

    task automatic model_step();
        logic [2:0] raw;
        logic [2:0] synced;
        logic [2:0] nd;
        logic       l, m, r, active, uniform;
        int         ns, nsaved, nlost, nspeed, tgt;
        raw = {left_track, mid_track, right_track};
        // Two flops of delay: the debouncer sees what was on the pins two edges ago.
        synced = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 3'b111;
        raw_q.push_back(raw);
        sync_q.push_back(synced);
        while (raw_q.size() > 8) void'(raw_q.pop_front());
        while (sync_q.size() > 8) void'(sync_q.pop_front());

        l = m_deb[2];
        m = m_deb[1];
        r = m_deb[0];
        active = (m_state == 1 || m_state == 2 || m_state == 3);
        ns = m_state;
        nsaved = m_saved;
        if (!run) ns = 0;
        else if (m_state == 0) ns = 1;
        else if (active && distance <= STOP) begin
            ns = 4;
            nsaved = m_state;
        end else if (m_state == 4) begin
            if (distance >= RESUME) ns = m_saved;
        end else if (active && m_lost_cnt == LOSTN) ns = 5;
        else if (m_state == 1) begin
            if (!r && l) ns = 3;
            else if (!l && r) ns = 2;
        end else if (active) begin
            if (!m) ns = 1;
        end else if (m_state == 5) begin
            if (m_deb != 3'b111) ns = 1;
        end

        if (active && m_deb == 3'b111) nlost = (m_lost_cnt < LOSTN) ? m_lost_cnt + 1 : LOSTN;
        else nlost = 0;

        tgt = target_of(m_state);
        nspeed = m_speed;
        if (tgt < m_speed) nspeed = tgt;
        else if (tgt > m_speed && (m_edge % DIV) == DIV - 1)
            nspeed = (m_speed + STEP > tgt) ? tgt : m_speed + STEP;

        // A debounced bit flips once its last DEB synced samples all agree and differ from it.
        nd = m_deb;
        if (sync_q.size() >= DEB) begin
            for (int b = 0; b < 3; b++) begin
                uniform = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (sync_q[sync_q.size()-1-j][b] != synced[b]) uniform = 1'b0;
                if (uniform && synced[b] != m_deb[b]) nd[b] = synced[b];
            end
        end

        m_state = ns;
        m_saved = nsaved;
        m_lost_cnt = nlost;
        m_speed = nspeed;
        m_deb = nd;
        m_edge++;
    endtask

    task automatic tick();
        logic [16:0] exp_v;
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        exp_v = {3'(m_state), 2'(mode_of(m_state)), 10'(m_speed), m_state == 4, m_state == 5};
        check("cycle", {15'd0, state_o, mode, speed, blocked, lost}, {15'd0, exp_v});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_tracks(input logic [2:0] t);
        {left_track, mid_track, right_track} = t;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state_o), 32'd0);
        check({tag, "_mode"}, 32'(mode), 32'd0);
        check({tag, "_speed"}, 32'(speed), 32'd0);
        check({tag, "_blocked"}, 32'(blocked), 32'd0);
        check({tag, "_lost"}, 32'(lost), 32'd0);
    endtask

    initial begin
        model_reset();
        ticks(3);
        check_reset_outputs("reset");

        // Start-up and ramp to cruise
        run = 1'b1;
        set_tracks(3'b101);
        distance = 6'd40;
        rst_n = 1'b1;
        tick();
        check("start_state", 32'(state_o), 32'd1);
        check("start_mode", 32'(mode), 32'd3);
        check("start_speed", 32'(speed), 32'd0);
        tick();
        check("ramp_first", 32'(speed), 32'd100);
        ticks(14);
        check("ramp_top", 32'(speed), 32'd800);
        ticks(4);
        check("ramp_hold", 32'(speed), 32'd800);

        // Right sensor on the line: turn right, then middle brings it back
        set_tracks(3'b110);
        ticks(10);
        check("turn_r_state", 32'(state_o), 32'd3);
        check("turn_r_mode", 32'(mode), 32'd1);
        check("turn_r_speed", 32'(speed), 32'd600);
        set_tracks(3'b101);
        ticks(10);
        check("back_fwd_state", 32'(state_o), 32'd1);
        ticks(20);
        check("back_fwd_speed", 32'(speed), 32'd800);

        // Short glitch shorter than the debounce window
        set_tracks(3'b100);
        ticks(3);
        set_tracks(3'b101);
        ticks(10);
        check("glitch_state", 32'(state_o), 32'd1);
        check("glitch_mode", 32'(mode), 32'd3);

        // Obstacle with hysteresis
        distance = 6'd8;
        ticks(2);
        check("block_speed", 32'(speed), 32'd0);
        check("block_flag", 32'(blocked), 32'd1);
        check("block_state", 32'(state_o), 32'd4);
        distance = 6'd10;
        ticks(5);
        check("hyst_state", 32'(state_o), 32'd4);
        distance = 6'd12;
        tick();
        check("resume_state", 32'(state_o), 32'd1);
        check("resume_flag", 32'(blocked), 32'd0);
        ticks(20);
        check("resume_speed", 32'(speed), 32'd800);

        // Line lost, then recovered by the left sensor
        distance = 6'd40;
        set_tracks(3'b111);
        ticks(70);
        check("lost_flag", 32'(lost), 32'd1);
        check("lost_state", 32'(state_o), 32'd5);
        check("lost_speed", 32'(speed), 32'd0);
        set_tracks(3'b011);
        begin
            int n;
            n = 0;
            while (state_o == 3'd5 && n < 20) begin
                tick();
                n++;
            end
        end
        check("unlost_state", 32'(state_o), 32'd1);
        check("unlost_flag", 32'(lost), 32'd0);

        // Drop run mid-turn
        set_tracks(3'b101);
        ticks(10);
        set_tracks(3'b110);
        ticks(10);
        check("turn2_state", 32'(state_o), 32'd3);
        run = 1'b0;
        tick();
        check("stop_state", 32'(state_o), 32'd0);
        check("stop_mode", 32'(mode), 32'd0);
        tick();
        check("stop_speed", 32'(speed), 32'd0);

        // Asynchronous reset in the middle of a ramp
        run = 1'b1;
        set_tracks(3'b101);
        ticks(6);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        ticks(2);
        rst_n = 1'b1;

        // Randomized drive
        for (int seg = 0; seg < 160; seg++) begin
            int len;
            run = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) begin
                set_tracks(3'b111);
                len = $urandom_range(55, 80);
            end else begin
                set_tracks(3'($urandom_range(0, 7)));
                len = $urandom_range(1, 12);
            end
            if ($urandom_range(0, 1) == 0) distance = 6'($urandom_range(6, 14));
            else distance = 6'($urandom_range(0, 63));
            ticks(len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
